// File: rtl/alu_ctl_pkg.sv
// rtl/alu_ctl_pkg.sv - shared ALU definitions: state encoding, op codes, settle default
package alu_ctl_pkg;

    localparam int SETTLE_CYCLES_DEF = 3;
    localparam int CNT_W             = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DRIVE  = 2'd2
    } alu_state_t;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_SHL  = 3'd5;
    localparam logic [2:0] OP_SHR  = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    // Counter preload: the counter reaches zero on the last settle cycle.
    function automatic logic [CNT_W-1:0] settle_load(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/alu_ctl_if.sv
// rtl/alu_ctl_if.sv - IBus / ALU ROM signal bundle for alu_ctl
interface alu_ctl_if;

    logic [15:0] ibus_in;
    logic        wb;
    logic [15:0] ac;
    logic [2:0]  op;
    logic        start;
    logic        clr_l;
    logic        clr_v;
    logic [15:0] rom_a;
    logic [15:0] rom_b;
    logic [2:0]  rom_op;
    logic        rom_fl;
    logic        rom_nsetl;
    logic        rom_flout;
    logic        rom_nsetv;
    logic        rom_fvout;
    logic        nromoe;
    logic        busy;
    logic        done;
    logic        fl;
    logic        fv;

    modport master (
        output ibus_in, wb, ac, op, start, clr_l, clr_v,
               rom_nsetl, rom_flout, rom_nsetv, rom_fvout,
        input  rom_a, rom_b, rom_op, rom_fl, nromoe, busy, done, fl, fv
    );

    modport slave (
        input  ibus_in, wb, ac, op, start, clr_l, clr_v,
               rom_nsetl, rom_flout, rom_nsetv, rom_fvout,
        output rom_a, rom_b, rom_op, rom_fl, nromoe, busy, done, fl, fv
    );

endinterface

// File: rtl/alu_settle_timer.sv
// rtl/alu_settle_timer.sv - loadable down-counter timing the operand settle window
module alu_settle_timer
    import alu_ctl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // Load on op start, count down while settling, never wrap below zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/alu_ctl.sv
// rtl/alu_ctl.sv - ALU ROM sequencer: operand hold, settle, result drive, L/V flags
module alu_ctl
    import alu_ctl_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic      clk,
    input  logic      reset,
    alu_ctl_if.slave  bus
);

    alu_state_t  state;
    logic [15:0] a_reg;
    logic [15:0] b_reg;
    logic [2:0]  op_reg;
    logic        l_flag;
    logic        v_flag;
    logic        busy_r;
    logic        done_r;
    logic        nromoe_r;
    logic        cnt_zero;
    logic        idle;
    logic        start_go;
    logic        in_drive;

    assign idle     = (state == ST_IDLE);
    assign in_drive = (state == ST_DRIVE);
    assign start_go = idle && bus.start;

    alu_settle_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (start_go),
        .load_val (settle_load(SETTLE_CYCLES)),
        .dec      (state == ST_SETTLE),
        .zero     (cnt_zero)
    );

    // Sequencer: captures A/OP on start, waits out the settle window, drives the result for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            a_reg    <= '0;
            op_reg   <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            nromoe_r <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_reg  <= bus.ac;
                        op_reg <= bus.op;
                        busy_r <= 1'b1;
                        state  <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_zero) begin
                        done_r   <= 1'b1;
                        nromoe_r <= 1'b0;
                        state    <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    done_r   <= 1'b0;
                    nromoe_r <= 1'b1;
                    busy_r   <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    done_r   <= 1'b0;
                    nromoe_r <= 1'b1;
                    busy_r   <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    // B operand loads from the IBus only when idle so it stays frozen for a running op.
    always_ff @(posedge clk) begin
        if (reset) begin
            b_reg <= '0;
        end else if (idle && bus.wb) begin
            b_reg <= bus.ibus_in;
        end
    end

    // Flags take the ROM result at the end of DRIVE; that update beats a same-edge clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            l_flag <= 1'b0;
            v_flag <= 1'b0;
        end else begin
            if (in_drive && !bus.rom_nsetl) begin
                l_flag <= bus.rom_flout;
            end else if (bus.clr_l) begin
                l_flag <= 1'b0;
            end
            if (in_drive && !bus.rom_nsetv) begin
                v_flag <= bus.rom_fvout;
            end else if (bus.clr_v) begin
                v_flag <= 1'b0;
            end
        end
    end

    assign bus.rom_a  = a_reg;
    assign bus.rom_b  = b_reg;
    assign bus.rom_op = op_reg;
    assign bus.rom_fl = l_flag;
    assign bus.nromoe = nromoe_r;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.fl     = l_flag;
    assign bus.fv     = v_flag;

endmodule

// File: tb/tb_alu_ctl.sv
// tb/tb_alu_ctl.sv - scoreboard bench for alu_ctl (SETTLE_CYCLES 3 and 1)
module tb_alu_ctl;

    localparam int SC3 = 3;
    localparam int SC1 = 1;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
        logic        fl;
        int          at_edge;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    alu_ctl_if if3 ();
    alu_ctl_if if1 ();

    alu_ctl #(.SETTLE_CYCLES(SC3)) dut3 (.clk(clk), .reset(reset), .bus(if3));
    alu_ctl #(.SETTLE_CYCLES(SC1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;

    exp_t q3[$];
    exp_t q1[$];
    exp_t e3;
    exp_t e1;

    logic [15:0] b_model;
    logic        l_model;
    logic        v_model;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // Scoreboard for the SETTLE_CYCLES=3 instance
    always @(negedge clk) begin
        if (if3.done === 1'b1) begin
            if (q3.size() == 0) begin
                check("sc3_unexpected_done", 32'(if3.done), 32'd0);
            end else begin
                e3 = q3.pop_front();
                check("sc3_done_edge", edge_n, e3.at_edge);
                check("sc3_drive_rom_a", if3.rom_a, e3.a);
                check("sc3_drive_rom_b", if3.rom_b, e3.b);
                check("sc3_drive_rom_op", if3.rom_op, e3.op);
                check("sc3_drive_rom_fl", if3.rom_fl, e3.fl);
                check("sc3_drive_nromoe", if3.nromoe, 1'b0);
            end
        end
    end

    // Scoreboard for the SETTLE_CYCLES=1 instance
    always @(negedge clk) begin
        if (if1.done === 1'b1) begin
            if (q1.size() == 0) begin
                check("sc1_unexpected_done", 32'(if1.done), 32'd0);
            end else begin
                e1 = q1.pop_front();
                check("sc1_done_edge", edge_n, e1.at_edge);
                check("sc1_drive_rom_a", if1.rom_a, e1.a);
                check("sc1_drive_rom_op", if1.rom_op, e1.op);
                check("sc1_drive_nromoe", if1.nromoe, 1'b0);
            end
        end
    end

    task automatic idle_inputs();
        if3.ibus_in = '0; if3.wb = 0; if3.ac = '0; if3.op = '0; if3.start = 0;
        if3.clr_l = 0; if3.clr_v = 0;
        if3.rom_nsetl = 1; if3.rom_flout = 0; if3.rom_nsetv = 1; if3.rom_fvout = 0;
        if1.ibus_in = '0; if1.wb = 0; if1.ac = '0; if1.op = '0; if1.start = 0;
        if1.clr_l = 0; if1.clr_v = 0;
        if1.rom_nsetl = 1; if1.rom_flout = 0; if1.rom_nsetv = 1; if1.rom_fvout = 0;
    endtask

    // Called just after a falling edge; runs one op on the SETTLE_CYCLES=3 instance.
    task automatic run_op(input logic [15:0] a, input logic [2:0] o,
                          input logic nsetl, input logic flout,
                          input logic nsetv, input logic fvout,
                          input bit disturb, input bit clr_drive);
        exp_t e;
        if3.ac = a; if3.op = o; if3.start = 1;
        if3.rom_nsetl = nsetl; if3.rom_flout = flout;
        if3.rom_nsetv = nsetv; if3.rom_fvout = fvout;
        e.a = a; e.b = b_model; e.op = o; e.fl = l_model;
        e.at_edge = edge_n + 1 + SC3;
        q3.push_back(e);
        for (int j = 0; j <= SC3 + 1; j++) begin
            @(negedge clk);
            if3.start = 0; if3.wb = 0; if3.clr_l = 0;
            check($sformatf("op_busy_j%0d", j), if3.busy, (j <= SC3));
            check($sformatf("op_done_j%0d", j), if3.done, (j == SC3));
            check($sformatf("op_nromoe_j%0d", j), if3.nromoe, (j != SC3));
            check($sformatf("op_rom_b_j%0d", j), if3.rom_b, e.b);
            check($sformatf("op_rom_fl_j%0d", j), if3.rom_fl, l_model);
            if (j <= SC3) begin
                check($sformatf("op_rom_a_j%0d", j), if3.rom_a, a);
                check($sformatf("op_rom_op_j%0d", j), if3.rom_op, o);
            end
            if (j == SC3 + 1) begin
                check("op_fl_after", if3.fl, l_model);
                check("op_fv_after", if3.fv, v_model);
            end
            if (j == SC3) begin
                if (!nsetl) l_model = flout;
                else if (clr_drive) l_model = 1'b0;
                if (!nsetv) v_model = fvout;
            end
            if (disturb && j == 0) begin
                if3.wb = 1; if3.ibus_in = 16'hAAAA; if3.start = 1; if3.ac = 16'h5555;
            end
            if (disturb && j == SC3) if3.start = 1;
            if (clr_drive && (j == SC3 || j == SC3 + 1)) if3.clr_l = 1;
        end
        @(negedge clk);
        if3.clr_l = 0; if3.start = 0;
        if (clr_drive) l_model = 1'b0;
        check("op_idle_busy", if3.busy, 1'b0);
        check("op_idle_fl", if3.fl, l_model);
        check("op_idle_rom_fl", if3.rom_fl, l_model);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        reset = 1;
        b_model = '0; l_model = 0; v_model = 0;
        if3.start = 1; if3.wb = 1; if3.ibus_in = 16'hFFFF; if3.clr_l = 0;
        repeat (3) @(negedge clk);
        check("rst_busy", if3.busy, 1'b0);
        check("rst_done", if3.done, 1'b0);
        check("rst_nromoe", if3.nromoe, 1'b1);
        check("rst_fl", if3.fl, 1'b0);
        check("rst_fv", if3.fv, 1'b0);
        check("rst_rom_a", if3.rom_a, 16'h0);
        check("rst_rom_b", if3.rom_b, 16'h0);
        check("rst_rom_op", if3.rom_op, 3'd0);
        idle_inputs();
        reset = 0;
        @(negedge clk);

        // B load from the IBus
        if3.wb = 1; if3.ibus_in = 16'h1234;
        @(negedge clk);
        if3.wb = 0; b_model = 16'h1234;
        check("wb_rom_b", if3.rom_b, 16'h1234);
        check("wb_fl", if3.fl, 1'b0);
        check("wb_fv", if3.fv, 1'b0);
        check("wb_nromoe", if3.nromoe, 1'b1);
        check("wb_busy", if3.busy, 1'b0);

        // Sets L, leaves V
        run_op(16'h00FF, 3'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        // Carries L in, sets V; wb/start during SETTLE and start during DRIVE ignored
        run_op(16'h0F0F, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Clear V while idle
        if3.clr_v = 1;
        @(negedge clk);
        if3.clr_v = 0; v_model = 0;
        check("clr_v_fv", if3.fv, 1'b0);

        // wb and start on the same edge: op sees the new B
        if3.wb = 1; if3.ibus_in = 16'hBEEF; b_model = 16'hBEEF;
        run_op(16'h7777, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // ROM flag update beats a same-edge clear; clear next cycle wins
        run_op(16'hC3C3, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

        // Leave both flags set before the abort test
        run_op(16'h8001, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset during the second SETTLE cycle aborts the op
        if3.ac = 16'h4321; if3.op = 3'd2; if3.start = 1;
        if3.rom_nsetl = 0; if3.rom_flout = 1; if3.rom_nsetv = 0; if3.rom_fvout = 1;
        @(negedge clk);
        if3.start = 0;
        check("abort_busy_before", if3.busy, 1'b1);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        b_model = '0; l_model = 0; v_model = 0;
        check("abort_busy", if3.busy, 1'b0);
        check("abort_nromoe", if3.nromoe, 1'b1);
        check("abort_done", if3.done, 1'b0);
        check("abort_fl", if3.fl, 1'b0);
        check("abort_fv", if3.fv, 1'b0);
        check("abort_rom_a", if3.rom_a, 16'h0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("abort_quiet_done_%0d", k), if3.done, 1'b0);
            check($sformatf("abort_quiet_nromoe_%0d", k), if3.nromoe, 1'b1);
        end

        // SETTLE_CYCLES=1: DRIVE directly after the single settle cycle
        begin
            exp_t e;
            if1.ac = 16'h0A0A; if1.op = 3'd6; if1.start = 1;
            e.a = 16'h0A0A; e.b = 16'h0; e.op = 3'd6; e.fl = 1'b0;
            e.at_edge = edge_n + 1 + SC1;
            q1.push_back(e);
            for (int j = 0; j <= SC1 + 1; j++) begin
                @(negedge clk);
                if1.start = 0;
                check($sformatf("sc1_busy_j%0d", j), if1.busy, (j <= SC1));
                check($sformatf("sc1_done_j%0d", j), if1.done, (j == SC1));
            end
        end

        repeat (2) @(negedge clk);
        check("sc3_queue_drained", q3.size(), 0);
        check("sc1_queue_drained", q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_ctl.md
ALU_CTL -- requirements
Module: alu_ctl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 3, number of clock cycles the operands are held stable before the result is driven; legal range 1..15.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ibus_in  input  16  IBus value; source for the B operand register.
REQ-005 wb  input  1  write B register from ibus_in.
REQ-006 ac  input  16  A operand (accumulator); captured at start.
REQ-007 op  input  3  ALU operation code; captured at start.
REQ-008 start  input  1  request one ALU operation.
REQ-009 clr_l, clr_v  input  1 each  clear L flag / V flag.
REQ-010 rom_a, rom_b  output  16 each  operand address bits to the ALU ROM.
REQ-011 rom_op  output  3  operation bits to the ALU ROM.
REQ-012 rom_fl  output  1  carry-in to the ALU ROM; equals current L flag.
REQ-013 rom_nsetl, rom_flout, rom_nsetv, rom_fvout  input  1 each  flag outputs returned by the ALU ROM.
REQ-014 nromoe  output  1  active-low enable of the ROM result onto the IBus.
REQ-015 busy  output  1  operation in progress.
REQ-016 done  output  1  one-cycle pulse, high during the result-drive cycle.
REQ-017 fl, fv  output  1 each  L and V flag register values.

Function
REQ-018 States: IDLE, SETTLE, DRIVE; two-bit encoding.
REQ-019 IDLE: start=1 -> capture ac into A reg, op into OP reg, load settle counter with SETTLE_CYCLES-1, go SETTLE.
REQ-020 SETTLE: counter decrements each cycle; at count 0 go DRIVE.
REQ-021 DRIVE: lasts exactly one cycle; nromoe=0, done=1; next state IDLE.
REQ-022 Latency: start sampled at edge N -> DRIVE cycle begins at edge N+SETTLE_CYCLES; busy high from edge N until edge N+SETTLE_CYCLES+1.
REQ-023 rom_a=A reg, rom_b=B reg, rom_op=OP reg at all times; constant from start capture to end of DRIVE.
REQ-024 wb in IDLE: B reg <= ibus_in at that edge; wb while busy is ignored (B stable for the op).
REQ-025 start while busy, including the DRIVE cycle, is ignored; no queuing; earliest back-to-back start is the first IDLE cycle.
REQ-026 wb and start same IDLE edge: B loaded and op started; the op uses the new B value.
REQ-027 Flag update at the edge ending DRIVE: rom_nsetl=0 -> L <= rom_flout; rom_nsetv=0 -> V <= rom_fvout; a 1 leaves the flag unchanged.
REQ-028 clr_l/clr_v clear the flag at the next edge; same-edge ROM flag update takes priority over clear.
REQ-029 L does not change during SETTLE or DRIVE except per REQ-027/028; rom_fl therefore stable for the whole op.
REQ-030 nromoe=1 and done=0 in every state other than DRIVE.

Reset
REQ-031 reset=1 at an edge: state IDLE, A/B/OP regs 0, counter 0, L=0, V=0, nromoe=1, busy=0, done=0, overriding all other inputs.
REQ-032 Reset during SETTLE or DRIVE aborts the op; no flag update, no done pulse.

Structure
REQ-033 State encoding, op-code constants and SETTLE_CYCLES default reside in the shared ALU definitions include used by the ALU ROM image build.
REQ-034 The settle counter is one sub-module, alu_settle_timer (load, decrement, zero flag); flags and FSM stay in alu_ctl.

Verification
REQ-035 Reset, then wb with ibus_in=0x1234 -> B=0x1234, rom_b=0x1234 next cycle, fl=fv=0, nromoe=1.
REQ-036 SETTLE_CYCLES=3, ac=0x00FF, op=3, start at edge 10 -> busy edges 10..14, DRIVE/done/nromoe=0 exactly cycle after edge 13, rom_a=0x00FF throughout.
REQ-037 In DRIVE, rom_nsetl=0, rom_flout=1, rom_nsetv=1 -> fl=1, fv unchanged after the op; rom_fl=1 on next op.
REQ-038 wb with 0xAAAA and start during SETTLE -> rom_b unchanged, no second op, single done pulse.
REQ-039 clr_l asserted same edge as DRIVE end with rom_nsetl=0, rom_flout=1 -> fl=1; clr_l next cycle -> fl=0.
REQ-040 reset pulsed in SETTLE cycle 2 -> IDLE next cycle, no done, nromoe stays 1, flags 0; SETTLE_CYCLES=1 run -> done one cycle after SETTLE.
